alu_ctrl_seq: RTL

- Hardwired control unit that sequences the 32-bit datapath through fetch, decode and execute for register-register ALU instructions (add, sub, and, or, ror, rol, shr, shl, mul), plus nop and halt.
- Replaces bench-driven control strobes: it produces every Xout/Xin strobe, Read, IncPC and the ALU operation select, cycle by cycle from IR.
- Sits beside the datapath and drives its control ports directly.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_wait_cnt.sv | 27 ++
 rtl/alu_ctrl_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, state encoding and strobe bundle for the ALU instruction sequencer.
package ctrl_pkg;

  localparam int unsigned OPW         = 5;
  localparam int unsigned RSW         = 4;
  localparam int unsigned MEM_TIMEOUT = 15;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  // Datapath control strobes, one bit per port.
  typedef struct packed {
    logic pcout;
    logic zhiout;
    logic zlowout;
    logic mdrout;
    logic marin;
    logic pcin;
    logic mdrin;
    logic irin;
    logic yin;
    logic zin;
    logic hiin;
    logic loin;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic incpc;
    logic read;
  } ctrl_strb_t;

  function automatic logic is_alu_op(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHL, OP_MUL: is_alu_op = 1'b1;
      default:                        is_alu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Loadable saturating wait counter; term_c flags that the next increment reaches MAX.
module ctrl_wait_cnt #(
  parameter int unsigned MAX = 15,
  localparam int unsigned CW = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic term_c
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (inc && (count != CW'(MAX))) begin
      count <= count + CW'(1);
    end
  end

  assign term_c = (count == CW'(MAX - 1));

endmodule

// File: rtl/alu_ctrl_seq.sv
// Hardwired fetch/decode/execute sequencer for register-register ALU instructions.
module alu_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic           run,
  input  logic [31:0]    IR,
  input  logic           mem_ack,
  output logic           PCout,
  output logic           Zhiout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           IncPC,
  output logic           Read,
  output logic [OPW-1:0] alu_op,
  output logic           busy,
  output logic           halted,
  output logic           fault
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [OPW-1:0]   opcode_c;
  ctrl_strb_t       strb_q, strb_d;
  logic [OPW-1:0]   alu_op_d;
  logic             busy_d, halted_d, fault_d;
  logic             cnt_load, cnt_inc, cnt_term_c;
  logic             unused_ir_c;

  assign opcode_c    = IR[31:31-OPW+1];
  assign unused_ir_c = ^IR[31-OPW:0];

  ctrl_wait_cnt #(.MAX(TIMEOUT)) u_wait_cnt (
    .clk    (Clock),
    .rst_n  (Clear),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .term_c (cnt_term_c)
  );

  // Next state, sticky fault and wait-counter control.
  always_comb begin
    state_d  = state_q;
    fault_d  = fault;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0: begin
        state_d  = ST_T1;
        cnt_load = 1'b1;
      end
      ST_T1: begin
        if (mem_ack) begin
          state_d = ST_T2;
        end else if (cnt_term_c) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        if (is_alu_op(opcode_c)) begin
          state_d = ST_T4;
        end else if (opcode_c == OP_NOP) begin
          state_d = run ? ST_T0 : ST_IDLE;
        end else if (opcode_c == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        if (op_q == OP_MUL) state_d = ST_T6;
        else                state_d = run ? ST_T0 : ST_IDLE;
      end
      ST_T6:   state_d = run ? ST_T0 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state so every output is a clean register.
  always_comb begin
    strb_d   = '0;
    alu_op_d = '0;
    case (state_d)
      ST_T0: begin
        strb_d.pcout = 1'b1;
        strb_d.marin = 1'b1;
        strb_d.incpc = 1'b1;
        strb_d.zin   = 1'b1;
      end
      ST_T1: begin
        strb_d.read  = 1'b1;
        strb_d.mdrin = 1'b1;
        if (state_q != ST_T1) begin
          strb_d.zlowout = 1'b1;
          strb_d.pcin    = 1'b1;
        end
      end
      ST_T2: begin
        strb_d.mdrout = 1'b1;
        strb_d.irin   = 1'b1;
      end
      ST_T3: begin
        strb_d.grb  = 1'b1;
        strb_d.rout = 1'b1;
        strb_d.yin  = 1'b1;
      end
      ST_T4: begin
        strb_d.grc  = 1'b1;
        strb_d.rout = 1'b1;
        strb_d.zin  = 1'b1;
        alu_op_d    = opcode_c;
      end
      ST_T5: begin
        strb_d.zlowout = 1'b1;
        if (op_q == OP_MUL) begin
          strb_d.loin = 1'b1;
        end else begin
          strb_d.gra = 1'b1;
          strb_d.rin = 1'b1;
        end
      end
      ST_T6: begin
        strb_d.zhiout = 1'b1;
        strb_d.hiin   = 1'b1;
      end
      default: strb_d = '0;
    endcase
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALT);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      strb_q  <= '0;
      alu_op  <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T3) op_q <= opcode_c;
      strb_q  <= strb_d;
      alu_op  <= alu_op_d;
      busy    <= busy_d;
      halted  <= halted_d;
      fault   <= fault_d;
    end
  end

  assign PCout   = strb_q.pcout;
  assign Zhiout  = strb_q.zhiout;
  assign Zlowout = strb_q.zlowout;
  assign MDRout  = strb_q.mdrout;
  assign MARin   = strb_q.marin;
  assign PCin    = strb_q.pcin;
  assign MDRin   = strb_q.mdrin;
  assign IRin    = strb_q.irin;
  assign Yin     = strb_q.yin;
  assign Zin     = strb_q.zin;
  assign HIin    = strb_q.hiin;
  assign LOin    = strb_q.loin;
  assign Gra     = strb_q.gra;
  assign Grb     = strb_q.grb;
  assign Grc     = strb_q.grc;
  assign Rin     = strb_q.rin;
  assign Rout    = strb_q.rout;
  assign IncPC   = strb_q.incpc;
  assign Read    = strb_q.read;

endmodule
